instruction_fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch stage. It owns the PC and issues pipelined, credit-limited requests to instruction memory, which may have variable latency. Returned instructions are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Redirects (branch-miss, return, branch, jump) flush the queue and discard stale in-flight responses. Sits between instruction memory and the decode stage.

---
 rtl/instruction_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch stage: owns the PC, issues credit-limited pipelined requests to instruction
//   memory, buffers returned instructions in a DEPTH-entry FIFO and hands them to decode
//   over a valid/ready handshake. Redirect commands flush the queue and drop stale
//   in-flight responses.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     When defined, a kept response arriving while the queue is empty is presented to
//     decode in the same cycle (and skips the queue if decode takes it).
//
// Ports
//   iClk, iReset                 clock, asynchronous active-high reset
//   oInstrMemAddress/Valid       request address (PC) and request valid
//   iInstrMemReady               request accepted when valid && ready
//   iInstrMemData/DataValid      in-order response data and strobe
//   oInstruction/oPC/oNextPC     head-of-queue instruction, its address, address + 1
//   oInstValid, iInstReady       decode handshake
//   iOffset                      jump offset (low 26 bits of the jump target)
//   iBranchAddr/iBranchMissAddr/iRetAddr   redirect targets
//   iBranchCmd/iBranchMissCmd/iJumpCmd/iRetCmd   redirect commands
//   iHalt                        stop issuing new requests

module instruction_fetch_queue #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              iClk,
    input  logic              iReset,
    output logic [ADDR_W-1:0] oInstrMemAddress,
    output logic              oInstrMemValid,
    input  logic              iInstrMemReady,
    input  logic [DATA_W-1:0] iInstrMemData,
    input  logic              iInstrMemDataValid,
    output logic [DATA_W-1:0] oInstruction,
    output logic [ADDR_W-1:0] oPC,
    output logic [ADDR_W-1:0] oNextPC,
    output logic              oInstValid,
    input  logic              iInstReady,
    input  logic [25:0]       iOffset,
    input  logic [ADDR_W-1:0] iBranchAddr,
    input  logic [ADDR_W-1:0] iBranchMissAddr,
    input  logic [ADDR_W-1:0] iRetAddr,
    input  logic              iBranchCmd,
    input  logic              iBranchMissCmd,
    input  logic              iJumpCmd,
    input  logic              iRetCmd,
    input  logic              iHalt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pcQ;
    logic [ADDR_W-1:0] respPcQ;     // address of the next response that will be kept
    logic [PTR_W-1:0]  headQ;
    logic [PTR_W-1:0]  tailQ;
    logic [CNT_W-1:0]  countQ;
    logic [CNT_W-1:0]  inflightQ;
    logic [CNT_W-1:0]  discardQ;    // stale responses still to be dropped

    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              queueValid;
    logic              respKeep;
    logic              bypassActive;
    logic              accept;
    logic              pop;
    logic              push;

    assign redirect   = iBranchCmd | iBranchMissCmd | iJumpCmd | iRetCmd;
    assign queueValid = (countQ != '0);
    assign respKeep   = iInstrMemDataValid && !redirect && (discardQ == '0);

`ifdef FETCH_BYPASS_EN
    assign bypassActive = respKeep && !queueValid;
`else
    assign bypassActive = 1'b0;
`endif

    always_comb begin
        target = {oNextPC[ADDR_W-1:26], iOffset};
        if (iBranchMissCmd) begin
            target = iBranchMissAddr;
        end else if (iRetCmd) begin
            target = iRetAddr;
        end else if (iBranchCmd) begin
            target = iBranchAddr;
        end
    end

    always_comb begin
        oInstruction = '0;
        oPC          = '0;
        if (queueValid) begin
            oInstruction = dataMem[headQ];
            oPC          = pcMem[headQ];
        end else if (bypassActive) begin
            oInstruction = iInstrMemData;
            oPC          = respPcQ;
        end
    end

    assign oInstValid = queueValid || bypassActive;
    assign oNextPC    = oInstValid ? oPC + ADDR_W'(1) : '0;

    // Credit rule: queued entries plus outstanding requests never exceed DEPTH.
    assign oInstrMemValid   = !iReset && !iHalt && !redirect &&
                              (({1'b0, countQ} + {1'b0, inflightQ}) < DEPTH_C);
    assign oInstrMemAddress = pcQ;

    assign accept = oInstrMemValid && iInstrMemReady;
    assign pop    = queueValid && iInstReady && !redirect;
    // A bypassed instruction taken by decode this cycle never enters the queue.
    assign push   = respKeep && !(bypassActive && iInstReady);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pcQ       <= RESET_PC;
            respPcQ   <= RESET_PC;
            headQ     <= '0;
            tailQ     <= '0;
            countQ    <= '0;
            inflightQ <= '0;
            discardQ  <= '0;
        end else begin
            inflightQ <= inflightQ + CNT_W'(accept) - CNT_W'(iInstrMemDataValid);
            if (redirect) begin
                pcQ      <= target;
                respPcQ  <= target;
                headQ    <= '0;
                tailQ    <= '0;
                countQ   <= '0;
                discardQ <= inflightQ - CNT_W'(iInstrMemDataValid);
            end else begin
                if (accept) begin
                    pcQ <= pcQ + ADDR_W'(1);
                end
                if (respKeep) begin
                    respPcQ <= respPcQ + ADDR_W'(1);
                end
                if (pop) begin
                    headQ <= headQ + PTR_W'(1);
                end
                if (push) begin
                    tailQ <= tailQ + PTR_W'(1);
                end
                countQ <= countQ + CNT_W'(push) - CNT_W'(pop);
                if (iInstrMemDataValid && (discardQ != '0)) begin
                    discardQ <= discardQ - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            dataMem[tailQ] <= iInstrMemData;
            pcMem[tailQ]   <= respPcQ;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              iClk = 1'b0;
    logic              iReset = 1'b1;
    logic [ADDR_W-1:0] oInstrMemAddress;
    logic              oInstrMemValid;
    logic              iInstrMemReady = 1'b0;
    logic [DATA_W-1:0] iInstrMemData = '0;
    logic              iInstrMemDataValid = 1'b0;
    logic [DATA_W-1:0] oInstruction;
    logic [ADDR_W-1:0] oPC;
    logic [ADDR_W-1:0] oNextPC;
    logic              oInstValid;
    logic              iInstReady = 1'b0;
    logic [25:0]       iOffset = '0;
    logic [ADDR_W-1:0] iBranchAddr = '0;
    logic [ADDR_W-1:0] iBranchMissAddr = '0;
    logic [ADDR_W-1:0] iRetAddr = '0;
    logic              iBranchCmd = 1'b0;
    logic              iBranchMissCmd = 1'b0;
    logic              iJumpCmd = 1'b0;
    logic              iRetCmd = 1'b0;
    logic              iHalt = 1'b0;

    always #5 iClk = ~iClk;

    instruction_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .iClk              (iClk),
        .iReset            (iReset),
        .oInstrMemAddress  (oInstrMemAddress),
        .oInstrMemValid    (oInstrMemValid),
        .iInstrMemReady    (iInstrMemReady),
        .iInstrMemData     (iInstrMemData),
        .iInstrMemDataValid(iInstrMemDataValid),
        .oInstruction      (oInstruction),
        .oPC               (oPC),
        .oNextPC           (oNextPC),
        .oInstValid        (oInstValid),
        .iInstReady        (iInstReady),
        .iOffset           (iOffset),
        .iBranchAddr       (iBranchAddr),
        .iBranchMissAddr   (iBranchMissAddr),
        .iRetAddr          (iRetAddr),
        .iBranchCmd        (iBranchCmd),
        .iBranchMissCmd    (iBranchMissCmd),
        .iJumpCmd          (iJumpCmd),
        .iRetCmd           (iRetCmd),
        .iHalt             (iHalt)
    );

    // Outstanding memory requests (also the memory model) and decode-visible queue.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] modelPc;
    int          cycle;
    int          lat;         // 0 selects a random latency of 1..4
    int          checks;
    int          errors;

    bit          sHalt, sInstReady, sMemReady, sBr, sMiss, sJmp, sRet;
    logic [31:0] sBrAddr, sMissAddr, sRetAddr;
    logic [25:0] sOffset;

    logic [31:0] issued[$];
    logic [31:0] popped[$];
    logic [31:0] poppedNext[$];
    logic [31:0] lastNextPC;
    bit          lastValid;
    bit          lastMemValid;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEADBEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    task automatic clearLogs();
        issued.delete();
        popped.delete();
        poppedNext.delete();
    endtask

    // One clock: drive inputs at negedge, compare against the model, advance the model.
    task automatic step();
        bit          respV, redirect, kept, bypass, expValid, expMemValid, popH, wasEmpty;
        logic [31:0] respAddr, expPC, expInstr, expNext, target;
        int          l, due;
        ent_t        e;
        req_t        r;
        @(negedge iClk);
        iReset          = 1'b0;
        iHalt           = sHalt;
        iInstReady      = sInstReady;
        iInstrMemReady  = sMemReady;
        iBranchCmd      = sBr;
        iBranchMissCmd  = sMiss;
        iJumpCmd        = sJmp;
        iRetCmd         = sRet;
        iBranchAddr     = sBrAddr;
        iBranchMissAddr = sMissAddr;
        iRetAddr        = sRetAddr;
        iOffset         = sOffset;
        respV    = 1'b0;
        respAddr = 32'h0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cycle) begin
                respV    = 1'b1;
                respAddr = pend[0].addr;
            end
        end
        iInstrMemDataValid = respV;
        iInstrMemData      = respV ? memData(respAddr) : $urandom;
        #1;
        redirect = sBr | sMiss | sJmp | sRet;
        kept     = respV && !redirect && !pend[0].stale;
        bypass   = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass = kept && (mq.size() == 0);
`endif
        expValid = (mq.size() > 0) || bypass;
        if (mq.size() > 0) begin
            expPC    = mq[0].pc;
            expInstr = mq[0].data;
        end else if (bypass) begin
            expPC    = respAddr;
            expInstr = memData(respAddr);
        end else begin
            expPC    = 32'h0;
            expInstr = 32'h0;
        end
        expNext     = expValid ? expPC + 32'h1 : 32'h0;
        expMemValid = !sHalt && !redirect && ((mq.size() + pend.size()) < DEPTH);

        check("instValid", {31'b0, oInstValid}, {31'b0, expValid});
        check("pc", oPC, expPC);
        check("nextPc", oNextPC, expNext);
        check("instruction", oInstruction, expInstr);
        check("memValid", {31'b0, oInstrMemValid}, {31'b0, expMemValid});
        if (expMemValid) check("memAddr", oInstrMemAddress, modelPc);

        lastNextPC   = oNextPC;
        lastValid    = oInstValid;
        lastMemValid = oInstrMemValid;
        if (oInstrMemValid && sMemReady) issued.push_back(oInstrMemAddress);
        if (oInstValid && sInstReady && !redirect) begin
            popped.push_back(oPC);
            poppedNext.push_back(oNextPC);
        end
        target = sMiss ? sMissAddr : sRet ? sRetAddr : sBr ? sBrAddr :
                 {expNext[31:26], sOffset};

        @(posedge iClk);
        popH     = expValid && sInstReady && !redirect;
        wasEmpty = (mq.size() == 0);
        if (redirect) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (respV) r = pend.pop_front();
            modelPc = target;
        end else begin
            if (respV) r = pend.pop_front();
            if (popH && !wasEmpty) e = mq.pop_front();
            if (kept && !(popH && wasEmpty)) begin
                e.pc   = respAddr;
                e.data = memData(respAddr);
                mq.push_back(e);
            end
            if (expMemValid && sMemReady) begin
                l   = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                due = cycle + l;
                if (pend.size() > 0) begin
                    if (pend[$].due >= due) due = pend[$].due + 1;
                end
                r.addr  = modelPc;
                r.due   = due;
                r.stale = 1'b0;
                pend.push_back(r);
                modelPc = modelPc + 32'h1;
            end
        end
        cycle++;
    endtask

    // Asserts reset mid-cycle; outputs must drop to zero immediately.
    task automatic doReset();
        @(negedge iClk);
        iReset             = 1'b1;
        iInstrMemDataValid = 1'b0;
        iBranchCmd         = 1'b0;
        iBranchMissCmd     = 1'b0;
        iJumpCmd           = 1'b0;
        iRetCmd            = 1'b0;
        #1;
        check("rstInstValid", {31'b0, oInstValid}, 32'h0);
        check("rstMemValid", {31'b0, oInstrMemValid}, 32'h0);
        check("rstPc", oPC, 32'h0);
        check("rstNextPc", oNextPC, 32'h0);
        check("rstInstruction", oInstruction, 32'h0);
        @(posedge iClk);
        @(posedge iClk);
        pend.delete();
        mq.delete();
        modelPc = 32'h0;
        sBr = 0; sMiss = 0; sJmp = 0; sRet = 0; sHalt = 0;
    endtask

    initial begin
        checks = 0; errors = 0; cycle = 0; lat = 1; modelPc = 32'h0;
        sHalt = 0; sInstReady = 1; sMemReady = 1;
        sBr = 0; sMiss = 0; sJmp = 0; sRet = 0;
        sBrAddr = '0; sMissAddr = '0; sRetAddr = '0; sOffset = '0;

        // Streaming with 1-cycle memory.
        doReset();
        clearLogs();
        repeat (12) step();
        check("p1Addr0", qget(issued, 0), 32'h0);
        check("p1Addr1", qget(issued, 1), 32'h1);
        check("p1Addr2", qget(issued, 2), 32'h2);
        check("p1Pc0", qget(popped, 0), 32'h0);
        check("p1Pc2", qget(popped, 2), 32'h2);
        check("p1Next0", qget(poppedNext, 0), 32'h1);
        check("p1Next2", qget(poppedNext, 2), 32'h3);
        check("p1Throughput", 32'(popped.size()), 32'd10);

        // Decode stalled: credits stop issue at DEPTH.
        doReset();
        sInstReady = 0;
        clearLogs();
        repeat (10) step();
        check("p2Issued", 32'(issued.size()), 32'd4);
        check("p2Addr3", qget(issued, 3), 32'h3);
        check("p2MemValidLow", {31'b0, lastMemValid}, 32'h0);
        sInstReady = 1;
        clearLogs();
        repeat (6) step();
        check("p2Pop0", qget(popped, 0), 32'h0);
        check("p2Pop3", qget(popped, 3), 32'h3);
        check("p2Resume", qget(issued, 0), 32'h4);

        // Redirect with 3 requests in flight.
        doReset();
        lat = 3;
        clearLogs();
        repeat (3) step();
        check("p3InFlight", 32'(issued.size()), 32'd3);
        sMiss = 1; sMissAddr = 32'h100; sJmp = 1; sOffset = 26'h3ABCDE;
        step();
        sMiss = 0; sJmp = 0;
        clearLogs();
        repeat (12) step();
        check("p3Addr", qget(issued, 0), 32'h100);
        check("p3FirstPc", qget(popped, 0), 32'h100);

        // Jump target keeps the upper bits of oNextPC.
        doReset();
        lat = 1;
        sInstReady = 0;
        sMiss = 1; sMissAddr = 32'h0800_0004;
        step();
        sMiss = 0;
        lastValid = 0;
        for (int i = 0; i < 20 && !lastValid; i++) step();
        check("p4Valid", {31'b0, lastValid}, 32'h1);
        sJmp = 1; sOffset = 26'h10;
        step();
        sJmp = 0;
        check("p4NextPc", lastNextPC, 32'h0800_0005);
        clearLogs();
        repeat (4) step();
        check("p4JumpAddr", qget(issued, 0), 32'h0800_0010);

        // Halt with 2 requests in flight.
        doReset();
        lat = 3;
        sInstReady = 1;
        repeat (2) step();
        sHalt = 1;
        clearLogs();
        repeat (8) step();
        check("p5NoIssue", 32'(issued.size()), 32'd0);
        check("p5Delivered", 32'(popped.size()), 32'd2);
        check("p5Pop1", qget(popped, 1), 32'h1);
        sHalt = 0;
        clearLogs();
        repeat (3) step();
        check("p5Resume", qget(issued, 0), 32'h2);

        // Address wrap, then reset mid-burst.
        doReset();
        lat = 1;
        sMiss = 1; sMissAddr = 32'hFFFF_FFFF;
        step();
        sMiss = 0;
        clearLogs();
        repeat (6) step();
        check("p6AddrTop", qget(issued, 0), 32'hFFFF_FFFF);
        check("p6AddrWrap", qget(issued, 1), 32'h0);
        check("p6PcTop", qget(popped, 0), 32'hFFFF_FFFF);
        check("p6NextWrap", qget(poppedNext, 0), 32'h0);
        check("p6PcWrap", qget(popped, 1), 32'h0);
        doReset();
        clearLogs();
        repeat (3) step();
        check("p6ResetPc", qget(issued, 0), 32'h0);

        // Randomized traffic against the model.
        doReset();
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            sHalt      = ($urandom_range(0, 99) < 10);
            sInstReady = ($urandom_range(0, 99) < 70);
            sMemReady  = ($urandom_range(0, 99) < 75);
            sBr = 0; sMiss = 0; sJmp = 0; sRet = 0;
            if ($urandom_range(0, 99) < 6) begin
                sBr   = $urandom_range(0, 1) == 1;
                sMiss = $urandom_range(0, 1) == 1;
                sJmp  = $urandom_range(0, 1) == 1;
                sRet  = $urandom_range(0, 1) == 1;
            end
            sBrAddr   = $urandom;
            sMissAddr = $urandom;
            sRetAddr  = $urandom;
            sOffset   = 26'($urandom);
            if ($urandom_range(0, 999) == 0) doReset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
